// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, reads the icache, hands
// instructions to the F/D latch, parks one instruction while the latch is
// frozen and handles redirect and halt.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        freeze,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] instr_out,
    output logic [31:0] npc_out,
    output logic        valid_out,
    output logic        flush_out,
    output logic        halted
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        HALT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   hbuf_instr_q, hbuf_instr_d;
    logic [XLEN-1:0]   hbuf_npc_q, hbuf_npc_d;
    logic              hbuf_valid_q, hbuf_valid_d;
    logic [XLEN-1:0]   pc_plus4_c;
    logic [XLEN-1:0]   redirect_tgt_c;

    // Sequential PC wraps modulo 2^32; redirect targets are word-aligned.
    assign pc_plus4_c     = pc_q + XLEN'(4);
    assign redirect_tgt_c = redirect_pc & 32'hFFFF_FFFC;

    // State, PC and hold buffer registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= RUN;
            pc_q         <= PC_INIT;
            hbuf_instr_q <= '0;
            hbuf_npc_q   <= '0;
            hbuf_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hbuf_instr_q <= hbuf_instr_d;
            hbuf_npc_q   <= hbuf_npc_d;
            hbuf_valid_q <= hbuf_valid_d;
        end
    end

    // Next-state and combinational outputs; priority halt > redirect > normal.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hbuf_instr_d = hbuf_instr_q;
        hbuf_npc_d   = hbuf_npc_q;
        hbuf_valid_d = hbuf_valid_q;
        imemREN      = 1'b0;
        imemaddr     = pc_q;
        instr_out    = '0;
        npc_out      = '0;
        valid_out    = 1'b0;
        flush_out    = 1'b0;
        halted       = 1'b0;

        if (nRST) begin
            case (state_q)
                RUN: begin
                    imemREN = 1'b1;
                    if (halt) begin
                        state_d      = HALT;
                        hbuf_valid_d = 1'b0;
                    end else if (redirect) begin
                        pc_d         = redirect_tgt_c;
                        hbuf_valid_d = 1'b0;
                        flush_out    = 1'b1;
                    end else if (ihit) begin
                        pc_d = pc_plus4_c;
                        if (!freeze) begin
                            instr_out = imemload;
                            npc_out   = pc_plus4_c;
                            valid_out = 1'b1;
                        end else begin
                            hbuf_instr_d = imemload;
                            hbuf_npc_d   = pc_plus4_c;
                            hbuf_valid_d = 1'b1;
                            state_d      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (halt) begin
                        state_d      = HALT;
                        hbuf_valid_d = 1'b0;
                    end else if (redirect) begin
                        pc_d         = redirect_tgt_c;
                        hbuf_valid_d = 1'b0;
                        flush_out    = 1'b1;
                        state_d      = RUN;
                    end else begin
                        instr_out = hbuf_instr_q;
                        npc_out   = hbuf_npc_q;
                        valid_out = hbuf_valid_q;
                        if (!freeze) begin
                            hbuf_valid_d = 1'b0;
                            state_d      = RUN;
                        end
                    end
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with hand-computed expectations.
module tb_fetch_unit;

    logic        clk;
    int          n_cmp;
    int          n_err;

    // DUT a: default PC_INIT
    logic        a_nrst, a_ren, a_ihit, a_freeze, a_redirect, a_halt;
    logic        a_valid, a_flush, a_halted;
    logic [31:0] a_addr, a_load, a_rpc, a_instr, a_npc;

    // DUT b: PC_INIT near the top of the address space
    logic        b_nrst, b_ren, b_ihit, b_valid, b_flush, b_halted;
    logic [31:0] b_addr, b_load, b_instr, b_npc;

    fetch_unit u_a (
        .CLK(clk), .nRST(a_nrst), .imemREN(a_ren), .imemaddr(a_addr),
        .ihit(a_ihit), .imemload(a_load), .freeze(a_freeze),
        .redirect(a_redirect), .redirect_pc(a_rpc), .halt(a_halt),
        .instr_out(a_instr), .npc_out(a_npc), .valid_out(a_valid),
        .flush_out(a_flush), .halted(a_halted)
    );

    fetch_unit #(.PC_INIT(32'hFFFF_FFF8)) u_b (
        .CLK(clk), .nRST(b_nrst), .imemREN(b_ren), .imemaddr(b_addr),
        .ihit(b_ihit), .imemload(b_load), .freeze(1'b0),
        .redirect(1'b0), .redirect_pc(32'h0), .halt(1'b0),
        .instr_out(b_instr), .npc_out(b_npc), .valid_out(b_valid),
        .flush_out(b_flush), .halted(b_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Full check of a normal RUN-cycle delivery at address pc.
    task automatic chk_run(input string tag, input logic [31:0] pc);
        chk32({tag, "_addr"}, a_addr, pc);
        chk1({tag, "_ren"}, a_ren, 1'b1);
        chk1({tag, "_valid"}, a_valid, 1'b1);
        chk32({tag, "_instr"}, a_instr, pc ^ 32'hA5A5_0000);
        chk32({tag, "_npc"}, a_npc, pc + 32'd4);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        a_nrst = 1'b0; a_ihit = 1'b0; a_freeze = 1'b0; a_redirect = 1'b0;
        a_halt = 1'b0; a_load = '0; a_rpc = '0;
        b_nrst = 1'b0; b_ihit = 1'b0; b_load = '0;

        // Reset state
        tick;
        a_ihit = 1'b1;
        #1;
        chk32("rst_addr", a_addr, 32'h0);
        chk1("rst_ren", a_ren, 1'b0);
        chk1("rst_valid", a_valid, 1'b0);
        chk1("rst_flush", a_flush, 1'b0);
        chk1("rst_halted", a_halted, 1'b0);
        chk32("rst_instr", a_instr, 32'h0);
        chk32("rst_npc", a_npc, 32'h0);
        a_nrst = 1'b1;

        // Back-to-back fetch at 0 and 4
        a_load = 32'h0000_0000 ^ 32'hA5A5_0000; #1;
        chk_run("f0", 32'h0);
        tick;
        a_load = 32'h0000_0004 ^ 32'hA5A5_0000; #1;
        chk_run("f4", 32'h4);
        tick;

        // Fetch at 8 while frozen: parked in hold buffer
        a_load = 32'h0000_0008 ^ 32'hA5A5_0000; a_freeze = 1'b1; #1;
        chk32("fz_addr", a_addr, 32'h8);
        chk1("fz_valid", a_valid, 1'b0);
        tick;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) a_freeze = 1'b0;
            #1;
            chk1("hold_ren", a_ren, 1'b0);
            chk1("hold_valid", a_valid, 1'b1);
            chk32("hold_instr", a_instr, 32'hA5A5_0008);
            chk32("hold_npc", a_npc, 32'hC);
            tick;
        end

        // Resume at C, run on to 0x1C
        for (int p = 12; p < 32; p += 4) begin
            a_load = 32'(p) ^ 32'hA5A5_0000; #1;
            chk_run("resume", 32'(p));
            tick;
        end

        // Redirect with ihit at 0x20 to misaligned 0x403
        a_load = 32'h0000_0020 ^ 32'hA5A5_0000; a_redirect = 1'b1; a_rpc = 32'h0000_0403; #1;
        chk32("rd_addr", a_addr, 32'h20);
        chk1("rd_flush", a_flush, 1'b1);
        chk1("rd_valid", a_valid, 1'b0);
        chk32("rd_instr", a_instr, 32'h0);
        tick;
        a_redirect = 1'b0;

        // Target 0x400 fetched under freeze -> HOLD
        a_load = 32'h0000_0400 ^ 32'hA5A5_0000; a_freeze = 1'b1; #1;
        chk32("tgt_addr", a_addr, 32'h400);
        chk1("tgt_flush", a_flush, 1'b0);
        chk1("tgt_valid", a_valid, 1'b0);
        tick;
        #1;
        chk32("h2_instr", a_instr, 32'hA5A5_0400);
        chk1("h2_valid", a_valid, 1'b1);
        tick;

        // Redirect while in HOLD drops the held instruction
        a_redirect = 1'b1; a_rpc = 32'h0000_0100; #1;
        chk1("rdh_flush", a_flush, 1'b1);
        chk1("rdh_valid", a_valid, 1'b0);
        chk32("rdh_instr", a_instr, 32'h0);
        tick;
        a_redirect = 1'b0; a_freeze = 1'b0;
        a_load = 32'h0000_0100 ^ 32'hA5A5_0000; #1;
        chk_run("rdh_tgt", 32'h100);
        tick;

        // halt and redirect together
        a_halt = 1'b1; a_redirect = 1'b1; a_rpc = 32'h0000_0200;
        a_load = 32'h0000_0104 ^ 32'hA5A5_0000; #1;
        chk1("hlt_valid", a_valid, 1'b0);
        chk1("hlt_halted0", a_halted, 1'b0);
        tick;
        a_halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a_freeze = i[0];
            #1;
            chk1("hlt_ren", a_ren, 1'b0);
            chk1("hlt_halted", a_halted, 1'b1);
            chk1("hlt_valid", a_valid, 1'b0);
            chk1("hlt_flush", a_flush, 1'b0);
            chk32("hlt_addr", a_addr, 32'h104);
            tick;
        end
        a_redirect = 1'b0; a_freeze = 1'b0;

        // Reset out of HALT
        a_nrst = 1'b0; #1;
        chk1("rsth_halted", a_halted, 1'b0);
        chk1("rsth_ren", a_ren, 1'b0);
        tick;
        a_nrst = 1'b1; #1;
        chk32("rsth_addr", a_addr, 32'h0);
        chk1("rsth_ren1", a_ren, 1'b1);
        chk1("rsth_halted1", a_halted, 1'b0);
        tick;

        // PC wrap on instance with PC_INIT=FFFF_FFF8
        b_nrst = 1'b1; b_ihit = 1'b1;
        b_load = 32'h1111_0000; #1;
        chk32("wr0_addr", b_addr, 32'hFFFF_FFF8);
        chk32("wr0_npc", b_npc, 32'hFFFF_FFFC);
        chk1("wr0_valid", b_valid, 1'b1);
        tick;
        b_load = 32'h2222_0000; #1;
        chk32("wr1_addr", b_addr, 32'hFFFF_FFFC);
        chk32("wr1_npc", b_npc, 32'h0000_0000);
        chk32("wr1_instr", b_instr, 32'h2222_0000);
        tick;
        b_load = 32'h3333_0000; #1;
        chk32("wr2_addr", b_addr, 32'h0000_0000);
        chk32("wr2_npc", b_npc, 32'h0000_0004);
        chk1("wr2_flush", b_flush, 1'b0);
        chk1("wr2_halted", b_halted, 1'b0);
        chk1("wr2_ren", b_ren, 1'b1);
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 5-stage pipeline; it sits directly upstream of the fetch/decode pipeline latch. Owns the program counter, issues instruction reads to the icache, and presents each fetched instruction with its next-PC to the F/D latch. Absorbs one instruction in a hold buffer when the latch is frozen and handles branch/jump redirects and halt.

## Interface
Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset; synchronous, active-low.
- imemREN  out  1  icache read enable.
- imemaddr  out  32  icache read address; equals pc.
- ihit  in  1  icache returns valid data for imemaddr this cycle.
- imemload  in  32  instruction word from the icache.
- freeze  in  1  F/D latch cannot accept this cycle.
- redirect  in  1  taken branch/jump resolved downstream.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- halt  in  1  halt committed; fetch stops permanently until reset.
- instr_out  out  32  instruction to F/D latch (instr_in).
- npc_out  out  32  pc+4 of that instruction to F/D latch (npc_in).
- valid_out  out  1  instr_out/npc_out are valid this cycle; this is the F/D latch ihit input.
- flush_out  out  1  squash the F/D latch contents (flush input).
- halted  out  1  fetch is in HALT.

## Operation
- State: pc (32b), hold buffer (hbuf_instr, hbuf_npc, hbuf_valid), FSM {RUN, HOLD, HALT}.
- RUN:
  - imemREN=1, imemaddr=pc.
  - On ihit && !freeze: instr_out=imemload, npc_out=pc+4, valid_out=1; pc<=pc+4.
  - On ihit && freeze: capture imemload/pc+4 into hbuf, hbuf_valid<=1, pc<=pc+4, go HOLD; valid_out=0 this cycle.
  - No ihit: valid_out=0, pc holds.
- HOLD:
  - imemREN=0. Outputs present hbuf contents with valid_out=1.
  - When !freeze, the latch consumes hbuf at the edge: hbuf_valid<=0, go RUN. The next fetch is issued the following cycle.
- HALT:
  - imemREN=0, valid_out=0, halted=1. Only reset exits this state.
- Priority, evaluated per cycle: halt > redirect > normal operation.
- halt (any state): go HALT, clear hbuf, valid_out=0 this cycle, pc holds.
- redirect (RUN or HOLD, no halt):
  - pc<={redirect_pc[31:2],2'b00}, clear hbuf, go RUN.
  - flush_out=1 and valid_out=0 this cycle.
  - An ihit in the same cycle is discarded, and pc does not increment.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC+4 = 32'h0000_0000. No misalignment fault.
- flush_out=0 whenever redirect=0.
- instr_out/npc_out are don't-care-free: they drive 0 when valid_out=0.

## Timing
- Reset (nRST low at an edge): pc<=PC_INIT, FSM<=RUN, hbuf_valid<=0.
- Outputs while nRST is low: imemREN=0, valid_out=0, flush_out=0, halted=0, instr_out=0, npc_out=0. imemaddr=pc.
- Reset asserted mid-HOLD or mid-HALT discards everything; the first request after release is PC_INIT.
- Fetch-to-output latency is 0 cycles: outputs are combinational from ihit/imemload, and the F/D latch registers them.
- Throughput is 1 instruction/cycle on back-to-back ihit with no freeze.
- Freeze recovery costs 1 bubble cycle: hbuf drains, then the next request is issued.
- Redirect takes effect at the next edge: the cycle after redirect, imemaddr=redirect target.
- freeze is ignored in HALT. freeze during a redirect cycle does not block flush_out.

## Test plan
- Reset, then ihit every cycle with imemload=pc^32'hA5A5_0000: imemaddr sequence 0,4,8,C; valid_out=1 each cycle; npc_out=4,8,C,10.
- Freeze for 3 cycles coinciding with ihit at pc=8: hbuf holds instr@8 with npc 12; valid_out=1 and imemREN=0 for 3 cycles; after freeze drops, the next imemaddr is 12; no instruction is lost or duplicated.
- redirect=1 with redirect_pc=32'h0000_0403 while ihit at pc=0x20: flush_out=1, valid_out=0 that cycle; the next imemaddr is 0x400; the 0x20 instruction never appears on instr_out.
- Redirect while in HOLD: hbuf is dropped; the next cycle is RUN at the target; the held instruction never appears.
- halt and redirect asserted together: halted=1 from the next cycle; imemREN stays 0 for 10 cycles despite ihit/redirect; nRST low for one edge then high → imemaddr=PC_INIT, halted=0.
- PC_INIT=32'hFFFF_FFF8 with 3 ihits: imemaddr sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; npc_out of the second fetch is 0.
